// File: rtl/ctech_lib_clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctech_lib_clk_div_pkg
// Description : Shared types and helpers for the programmable clock divider.
//               - state_t     : divider run state (STOPPED / RUN / STOPPING)
//               - clamp_ratio : forces ratios 0 and 1 up to 2
//               - high_len    : ceil(N/2), length of the high phase
// Revision    : 1.0 - initial release
// ============================================================================
package ctech_lib_clk_div_pkg;

    typedef enum logic [1:0] {
        STOPPED  = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    // Ratios below 2 cannot produce a clock, so they are promoted to 2.
    function automatic logic [31:0] clamp_ratio(input logic [31:0] ratio);
        return (ratio < 32'd2) ? 32'd2 : ratio;
    endfunction

    function automatic logic [31:0] high_len(input logic [31:0] ratio);
        return (ratio + 32'd1) >> 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctech_lib_clk_div_odd50.sv
`default_nettype none
// ============================================================================
// Module      : ctech_lib_clk_div_odd50
// Description : Half-cycle extender for odd divide ratios. A falling-edge
//               flop trails the posedge high-phase term by half a clk period;
//               OR-ing the two stretches the high phase by 0.5 cycle, giving
//               exactly 50% duty for odd N. Even N passes through unchanged.
//               Only instantiated when CTECH_CLK_DIV_ODD50_EN is defined.
// Ports       : clk      - source clock
//               rstb     - asynchronous active-low reset
//               pos_term - posedge high-phase term (high floor(N/2) cycles)
//               odd      - active ratio is odd
//               clkout   - combined divided clock
// Revision    : 1.0 - initial release
// ============================================================================
module ctech_lib_clk_div_odd50 (
    input  logic clk,
    input  logic rstb,
    input  logic pos_term,
    input  logic odd,
    output logic clkout
);

    logic r_neg;

    always_ff @(negedge clk or negedge rstb) begin
        if (!rstb) begin
            r_neg <= 1'b0;
        end else begin
            r_neg <= pos_term & odd;
        end
    end

    assign clkout = pos_term | r_neg;

endmodule
`default_nettype wire

// File: rtl/ctech_lib_clk_divider_prog_rstb.sv
`default_nettype none
// ============================================================================
// Module      : ctech_lib_clk_divider_prog_rstb
// Description : Programmable integer clock divider. Divides clk by a runtime
//               loadable ratio N (2 .. 2^DIV_W-1). Ratio changes and
//               enable/disable only take effect at period boundaries so
//               clkout never emits a truncated pulse.
//               Optional macro CTECH_CLK_DIV_ODD50_EN adds a negedge stage
//               for exact 50% duty on odd ratios.
// Ports       : clk       - source clock
//               rstb      - asynchronous active-low reset
//               en        - run request (level)
//               div_load  - one-cycle pulse, capture div_ratio as pending
//               div_ratio - requested ratio (0/1 clamped to 2)
//               clkout    - divided clock
//               div_busy  - pending ratio not yet applied
//               div_ack   - one-cycle pulse when pending ratio becomes active
//               running   - high in RUN and STOPPING
// Revision    : 1.0 - initial release
// ============================================================================
module ctech_lib_clk_divider_prog_rstb
    import ctech_lib_clk_div_pkg::*;
#(
    parameter int DIV_W       = 4,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_ratio,
    output logic             clkout,
    output logic             div_busy,
    output logic             div_ack,
    output logic             running
);

    localparam logic [DIV_W-1:0] c_DEFAULT_RATIO = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] c_ONE           = DIV_W'(1);
    localparam logic [DIV_W-1:0] c_ZERO          = '0;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_ratio;
    logic [DIV_W-1:0] r_pend;
    logic             r_busy;
    logic             r_ack;
    logic             r_pos;

    logic [DIV_W-1:0] w_load_val;
    logic [DIV_W-1:0] w_high;
    logic             w_wrap;
    logic             w_counting;
    logic             w_apply;

    assign w_load_val = DIV_W'(clamp_ratio(32'(div_ratio)));

`ifdef CTECH_CLK_DIV_ODD50_EN
    // Posedge term covers floor(N/2); the negedge stage adds the missing half.
    assign w_high = r_ratio >> 1;
`else
    assign w_high = DIV_W'(high_len(32'(r_ratio)));
`endif

    assign w_wrap     = (r_cnt == (r_ratio - c_ONE));
    // STOPPED only counts on the edge that starts a new run.
    assign w_counting = (r_state != STOPPED) || en;
    // In STOPPED cnt is 0, so w_wrap cannot fire there; the STOPPED term
    // lets a pending ratio land on the very next edge.
    assign w_apply    = r_busy && ((r_state == STOPPED) || w_wrap);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            STOPPED: begin
                if (en) w_state_nxt = RUN;
            end
            RUN: begin
                if (!en) w_state_nxt = STOPPING;
            end
            STOPPING: begin
                if (w_wrap)  w_state_nxt = STOPPED;
                else if (en) w_state_nxt = RUN;
            end
            default: w_state_nxt = STOPPED;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= STOPPED;
            r_cnt   <= c_ZERO;
            r_ratio <= c_DEFAULT_RATIO;
            r_pend  <= c_DEFAULT_RATIO;
            r_busy  <= 1'b0;
            r_ack   <= 1'b0;
            r_pos   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_counting) begin
                r_pos <= (r_cnt < w_high);
                r_cnt <= w_wrap ? c_ZERO : (r_cnt + c_ONE);
            end else begin
                r_pos <= 1'b0;
                r_cnt <= c_ZERO;
            end

            if (div_load) begin
                r_pend <= w_load_val;
            end

            // A load coinciding with the application edge wins over the
            // older pending value and is consumed immediately.
            if (w_apply) begin
                r_ratio <= div_load ? w_load_val : r_pend;
                r_busy  <= 1'b0;
            end else if (div_load) begin
                r_busy  <= 1'b1;
            end

            r_ack <= w_apply;
        end
    end

`ifdef CTECH_CLK_DIV_ODD50_EN
    ctech_lib_clk_div_odd50 u_odd50 (
        .clk      (clk),
        .rstb     (rstb),
        .pos_term (r_pos),
        .odd      (r_ratio[0]),
        .clkout   (clkout)
    );
`else
    assign clkout = r_pos;
`endif

    assign div_busy = r_busy;
    assign div_ack  = r_ack;
    assign running  = (r_state != STOPPED);

endmodule
`default_nettype wire

// File: tb/tb_ctech_lib_clk_divider_prog_rstb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctech_lib_clk_divider_prog_rstb
// Description : Directed self-checking bench for the programmable divider
//               (default build, DIV_W=4, DEFAULT_DIV=2). Inputs change 1ns
//               after a rising edge; outputs are sampled at that same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctech_lib_clk_divider_prog_rstb;

    logic       clk;
    logic       rstb;
    logic       en;
    logic       div_load;
    logic [3:0] div_ratio;
    logic       clkout;
    logic       div_busy;
    logic       div_ack;
    logic       running;

    int checks = 0;
    int errors = 0;

    ctech_lib_clk_divider_prog_rstb #(
        .DIV_W       (4),
        .DEFAULT_DIV (2)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .en        (en),
        .div_load  (div_load),
        .div_ratio (div_ratio),
        .clkout    (clkout),
        .div_busy  (div_busy),
        .div_ack   (div_ack),
        .running   (running)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] pat;
        pat = 4'b1010;
        rstb = 1'b0; en = 1'b1; div_load = 1'b0; div_ratio = 4'd0;
        repeat (2) step();
        checks++; if (clkout !== 1'b0)   begin errors++; $display("FAIL reset_clkout actual=%b required=0", clkout); end
        checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b required=0", div_busy); end
        checks++; if (div_ack !== 1'b0)  begin errors++; $display("FAIL reset_ack actual=%b required=0", div_ack); end
        checks++; if (running !== 1'b0)  begin errors++; $display("FAIL reset_running actual=%b required=0", running); end
        rstb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (clkout !== pat[3-i]) begin errors++; $display("FAIL start_div2_clkout[%0d] actual=%b required=%b", i, clkout, pat[3-i]); end
            checks++; if (running !== 1'b1)    begin errors++; $display("FAIL start_running[%0d] actual=%b required=1", i, running); end
        end
    endtask

    // Entry: RUN, N=2, cnt=0. Exit: RUN, N=5, cnt=0.
    task automatic test_load5();
        logic [9:0] pat;
        pat = 10'b1110011100;
        div_load = 1'b1; div_ratio = 4'd5;
        step();
        div_load = 1'b0;
        checks++; if (div_busy !== 1'b1) begin errors++; $display("FAIL load5_busy actual=%b required=1", div_busy); end
        checks++; if (div_ack !== 1'b0)  begin errors++; $display("FAIL load5_early_ack actual=%b required=0", div_ack); end
        step();
        checks++; if (div_ack !== 1'b1)  begin errors++; $display("FAIL load5_ack actual=%b required=1", div_ack); end
        checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL load5_busy_clear actual=%b required=0", div_busy); end
        checks++; if (clkout !== 1'b0)   begin errors++; $display("FAIL load5_wrap_clkout actual=%b required=0", clkout); end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (clkout !== pat[9-i]) begin errors++; $display("FAIL div5_clkout[%0d] actual=%b required=%b", i, clkout, pat[9-i]); end
            checks++; if (div_ack !== 1'b0)    begin errors++; $display("FAIL div5_ack_single[%0d] actual=%b required=0", i, div_ack); end
        end
    endtask

    // Entry: RUN, N=5, cnt=0. Exit: RUN, N=6, cnt=0.
    task automatic test_stop();
        logic [4:0] pat_clk;
        logic [4:0] pat_run;
        pat_clk = 5'b11000;
        pat_run = 5'b11110;
        div_load = 1'b1; div_ratio = 4'd6;
        step();
        div_load = 1'b0;
        repeat (4) step();
        checks++; if (div_ack !== 1'b1) begin errors++; $display("FAIL load6_ack actual=%b required=1", div_ack); end
        step();
        checks++; if (clkout !== 1'b1)  begin errors++; $display("FAIL div6_first_high actual=%b required=1", clkout); end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (clkout !== pat_clk[4-i])  begin errors++; $display("FAIL stop_clkout[%0d] actual=%b required=%b", i, clkout, pat_clk[4-i]); end
            checks++; if (running !== pat_run[4-i]) begin errors++; $display("FAIL stop_running[%0d] actual=%b required=%b", i, running, pat_run[4-i]); end
        end
        step();
        checks++; if (clkout !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL stopped_idle actual=%b%b required=00", clkout, running); end
        en = 1'b1;
        step();
        checks++; if (clkout !== 1'b1 || running !== 1'b1) begin errors++; $display("FAIL restart actual=%b%b required=11", clkout, running); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (clkout !== pat_clk[4-i]) begin errors++; $display("FAIL restart_clkout[%0d] actual=%b required=%b", i, clkout, pat_clk[4-i]); end
        end
    endtask

    // Entry: RUN, N=6, cnt=0. Exit: RUN, N=7, cnt=0.
    task automatic test_back_to_back();
        logic [6:0] pat;
        int acks;
        pat = 7'b1111000;
        acks = 0;
        div_load = 1'b1; div_ratio = 4'd3;
        step();
        div_ratio = 4'd7;
        step();
        div_load = 1'b0;
        checks++; if (div_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy actual=%b required=1", div_busy); end
        for (int i = 0; i < 4; i++) begin
            step();
            if (div_ack === 1'b1) acks++;
        end
        checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_clear actual=%b required=0", div_busy); end
        for (int i = 0; i < 7; i++) begin
            step();
            if (div_ack === 1'b1) acks++;
            checks++; if (clkout !== pat[6-i]) begin errors++; $display("FAIL div7_clkout[%0d] actual=%b required=%b", i, clkout, pat[6-i]); end
        end
        checks++; if (acks != 1) begin errors++; $display("FAIL b2b_ack_count actual=%0d required=1", acks); end
    endtask

    // Entry: RUN, N=7, cnt=0. Exit: RUN, N=2, cnt=0.
    task automatic test_clamp();
        logic [3:0] pat;
        pat = 4'b1010;
        div_load = 1'b1; div_ratio = 4'd0;
        step();
        div_load = 1'b0;
        repeat (6) step();
        checks++; if (div_ack !== 1'b1) begin errors++; $display("FAIL clamp0_ack actual=%b required=1", div_ack); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (clkout !== pat[3-i]) begin errors++; $display("FAIL clamp0_clkout[%0d] actual=%b required=%b", i, clkout, pat[3-i]); end
        end
        div_load = 1'b1; div_ratio = 4'd1;
        step();
        div_load = 1'b0;
        step();
        checks++; if (div_ack !== 1'b1) begin errors++; $display("FAIL clamp1_ack actual=%b required=1", div_ack); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (clkout !== pat[3-i]) begin errors++; $display("FAIL clamp1_clkout[%0d] actual=%b required=%b", i, clkout, pat[3-i]); end
        end
    endtask

    // Entry: RUN, N=2, cnt=0.
    task automatic test_reset_mid();
        logic [3:0] pat;
        pat = 4'b1010;
        div_load = 1'b1; div_ratio = 4'd5;
        step();
        div_load = 1'b0;
        step();
        step();
        div_load = 1'b1; div_ratio = 4'd9;
        step();
        div_load = 1'b0;
        checks++; if (clkout !== 1'b1 || div_busy !== 1'b1 || running !== 1'b1) begin
            errors++; $display("FAIL pre_reset actual=%b%b%b required=111", clkout, div_busy, running);
        end
        #2 rstb = 1'b0;
        #1;
        checks++; if (clkout !== 1'b0)   begin errors++; $display("FAIL async_clkout actual=%b required=0", clkout); end
        checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL async_busy actual=%b required=0", div_busy); end
        checks++; if (div_ack !== 1'b0)  begin errors++; $display("FAIL async_ack actual=%b required=0", div_ack); end
        checks++; if (running !== 1'b0)  begin errors++; $display("FAIL async_running actual=%b required=0", running); end
        #2 rstb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (clkout !== pat[3-i]) begin errors++; $display("FAIL post_reset_div2[%0d] actual=%b required=%b", i, clkout, pat[3-i]); end
            checks++; if (div_ack !== 1'b0 || div_busy !== 1'b0) begin
                errors++; $display("FAIL post_reset_pending[%0d] actual=%b%b required=00", i, div_ack, div_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load5();
        test_stop();
        test_back_to_back();
        test_clamp();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
